// File: rtl/core_reset_ctrl.sv
// rtl/core_reset_ctrl.sv - core reset request generator with watchdog, release handshake and cause capture
// Holds o_resetn low for PULSE_CYCLES per request and waits for the core synchronizer to report release.
module core_reset_ctrl #(
    parameter int PULSE_CYCLES    = 32,
    parameter int WDT_WIDTH       = 16,
    parameter int RELEASE_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_sw_req,
    input  logic                 i_wdt_en,
    input  logic [WDT_WIDTH-1:0] i_wdt_load,
    input  logic                 i_wdt_kick,
    input  logic                 i_core_resetn,
    output logic                 o_resetn,
    output logic                 o_busy,
    output logic [1:0]           o_cause,
    output logic [WDT_WIDTH-1:0] o_wdt_count
);

    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int TW = (RELEASE_TIMEOUT > 1) ? $clog2(RELEASE_TIMEOUT) : 1;

    localparam logic [1:0] CAUSE_POR     = 2'b00;
    localparam logic [1:0] CAUSE_SW      = 2'b01;
    localparam logic [1:0] CAUSE_WDT     = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_IDLE    = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        pulse_q, pulse_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [WDT_WIDTH-1:0] wdt_q, wdt_d;
    logic [1:0]           cause_q, cause_d;
    logic                 resetn_q, resetn_d;
    logic                 busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_ASSERT;
            pulse_q  <= '0;
            tmo_q    <= '0;
            wdt_q    <= '1;
            cause_q  <= CAUSE_POR;
            resetn_q <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            tmo_q    <= tmo_d;
            wdt_q    <= wdt_d;
            cause_q  <= cause_d;
            resetn_q <= resetn_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        tmo_d   = tmo_q;
        wdt_d   = wdt_q;
        cause_d = cause_q;
        unique case (state_q)
            ST_ASSERT: begin
                if (pulse_q == PW'(PULSE_CYCLES - 1)) begin
                    state_d = ST_RELEASE;
                    tmo_d   = '0;
                end else begin
                    pulse_d = pulse_q + PW'(1);
                end
            end
            ST_RELEASE: begin
                if (i_core_resetn) begin
                    state_d = ST_IDLE;
                    wdt_d   = i_wdt_load;
                end else if (tmo_q == TW'(RELEASE_TIMEOUT - 1)) begin
                    state_d = ST_ASSERT;
                    pulse_d = '0;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_IDLE: begin
                // Expiry outranks a same-cycle software request; a kick on that cycle saves it.
                if (i_wdt_en && (wdt_q == '0) && !i_wdt_kick) begin
                    state_d = ST_ASSERT;
                    pulse_d = '0;
                    cause_d = CAUSE_WDT;
                end else if (i_sw_req) begin
                    state_d = ST_ASSERT;
                    pulse_d = '0;
                    cause_d = CAUSE_SW;
                end else if (i_wdt_kick || !i_wdt_en) begin
                    wdt_d = i_wdt_load;
                end else begin
                    wdt_d = wdt_q - WDT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_ASSERT;
                pulse_d = '0;
            end
        endcase
    end

    always_comb begin
        resetn_d = (state_d != ST_ASSERT);
        busy_d   = (state_d != ST_IDLE);
    end

    assign o_resetn    = resetn_q;
    assign o_busy      = busy_q;
    assign o_cause     = cause_q;
    assign o_wdt_count = wdt_q;

endmodule

// File: tb/tb_core_reset_ctrl.sv
// tb/tb_core_reset_ctrl.sv - directed self-checking bench for core_reset_ctrl
// A phase/countdown model is compared every cycle; directed literals pin pulse lengths and causes.
module tb_core_reset_ctrl;

    localparam int P = 32;
    localparam int T = 64;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         i_sw_req = 1'b0;
    logic         i_wdt_en = 1'b0;
    logic [W-1:0] i_wdt_load = 16'd10;
    logic         i_wdt_kick = 1'b0;
    logic         i_core_resetn;
    logic         o_resetn;
    logic         o_busy;
    logic [1:0]   o_cause;
    logic [W-1:0] o_wdt_count;

    int total = 0;
    int bad = 0;

    logic        force0 = 1'b0;
    logic [15:0] hist = '0;

    core_reset_ctrl #(.PULSE_CYCLES(P), .WDT_WIDTH(W), .RELEASE_TIMEOUT(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_sw_req     (i_sw_req),
        .i_wdt_en     (i_wdt_en),
        .i_wdt_load   (i_wdt_load),
        .i_wdt_kick   (i_wdt_kick),
        .i_core_resetn(i_core_resetn),
        .o_resetn     (o_resetn),
        .o_busy       (o_busy),
        .o_cause      (o_cause),
        .o_wdt_count  (o_wdt_count)
    );

    always #5 clk = ~clk;

    // Core synchronizer stand-in: released indication trails o_resetn by 16 cycles.
    always @(negedge clk) hist <= {hist[14:0], o_resetn};
    assign i_core_resetn = force0 ? 1'b0 : hist[15];

    // Model: phase 0 = pulse low, 1 = waiting for release, 2 = running.
    int           m_phase;
    int           m_low_left;
    int           m_waited;
    logic [1:0]   m_cause;
    logic [W-1:0] m_wdt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase    <= 0;
            m_low_left <= P;
            m_waited   <= 0;
            m_cause    <= 2'd0;
            m_wdt      <= '1;
        end else if (m_phase == 0) begin
            m_low_left <= m_low_left - 1;
            if (m_low_left == 1) begin
                m_phase  <= 1;
                m_waited <= 0;
            end
        end else if (m_phase == 1) begin
            if (i_core_resetn) begin
                m_phase <= 2;
                m_wdt   <= i_wdt_load;
            end else if (m_waited + 1 >= T) begin
                m_phase    <= 0;
                m_low_left <= P;
                m_cause    <= 2'd3;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else begin
            if (i_wdt_en && m_wdt == 0 && !i_wdt_kick) begin
                m_phase    <= 0;
                m_low_left <= P;
                m_cause    <= 2'd2;
            end else if (i_sw_req) begin
                m_phase    <= 0;
                m_low_left <= P;
                m_cause    <= 2'd1;
            end else if (i_wdt_kick || !i_wdt_en) begin
                m_wdt <= i_wdt_load;
            end else begin
                m_wdt <= m_wdt - 1'b1;
            end
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        chk("model_resetn", {31'd0, o_resetn}, {31'd0, m_phase != 0});
        chk("model_busy", {31'd0, o_busy}, {31'd0, m_phase != 2});
        chk("model_cause", {30'd0, o_cause}, {30'd0, m_cause});
        chk("model_wdt", {16'd0, o_wdt_count}, {16'd0, m_wdt});
    end

    task automatic wait_high(output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!o_resetn && n < 300);
    endtask

    task automatic wait_low(output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (o_resetn && n < 300);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (o_busy && n < 300);
    endtask

    task automatic sw_pulse();
        @(negedge clk); i_sw_req = 1'b1;
        @(negedge clk); i_sw_req = 1'b0;
    endtask

    task automatic wait_count_zero();
        int k;
        k = 0;
        while (o_wdt_count != 0 && k < 40) begin @(negedge clk); k++; end
        chk("wdt_reached_zero", {16'd0, o_wdt_count}, 32'd0);
    endtask

    initial begin
        int n;
        bit kicked;
        // Power-on
        #1 reset = 1'b1;
        #1;
        chk("por_resetn", {31'd0, o_resetn}, 32'd0);
        chk("por_busy", {31'd0, o_busy}, 32'd1);
        chk("por_cause", {30'd0, o_cause}, 32'd0);
        chk("por_wdt", {16'd0, o_wdt_count}, 32'hffff);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_high(n);  chk("por_low_len", n, P);
        wait_idle(n);  chk("por_release_len", n, 16);
        chk("por_idle_busy", {31'd0, o_busy}, 32'd0);
        chk("por_idle_cause", {30'd0, o_cause}, 32'd0);

        // Software request, with a second request ignored mid-pulse
        sw_pulse();
        chk("sw_latency", {31'd0, o_resetn}, 32'd0);
        chk("sw_cause", {30'd0, o_cause}, 32'd1);
        fork
            begin
                repeat (5) @(negedge clk);
                i_sw_req = 1'b1;
                @(negedge clk);
                i_sw_req = 1'b0;
            end
        join_none
        wait_high(n);  chk("sw_low_len", n, P);
        wait_idle(n);  chk("sw_release_len", n, 16);

        // Watchdog countdown to expiry
        @(negedge clk);
        i_wdt_en = 1'b1;
        for (int e = 10; e >= 0; e--) begin
            chk("wdt_count", {16'd0, o_wdt_count}, e);
            @(negedge clk);
        end
        chk("wdt_expire_resetn", {31'd0, o_resetn}, 32'd0);
        chk("wdt_expire_cause", {30'd0, o_cause}, 32'd2);
        wait_high(n);  chk("wdt_low_len", n, P);
        wait_idle(n);

        // Kick at count 3 reloads
        kicked = 1'b0;
        for (int k = 0; k < 40 && !kicked; k++) begin
            @(negedge clk);
            if (o_wdt_count == 3) begin
                i_wdt_kick = 1'b1;
                kicked = 1'b1;
                @(negedge clk);
                i_wdt_kick = 1'b0;
                i_wdt_en = 1'b0;
                chk("kick_reload", {16'd0, o_wdt_count}, 32'd10);
                chk("kick_no_reset", {31'd0, o_busy}, 32'd0);
            end
        end
        chk("kick_seen", {31'd0, kicked}, 32'd1);

        // Simultaneous expiry and software request
        @(negedge clk); i_wdt_en = 1'b1;
        wait_count_zero();
        i_sw_req = 1'b1;
        @(negedge clk); i_sw_req = 1'b0;
        chk("sim_wdt_wins", {30'd0, o_cause}, 32'd2);
        wait_high(n);
        wait_idle(n);
        wait_count_zero();
        i_sw_req = 1'b1; i_wdt_kick = 1'b1;
        @(negedge clk); i_sw_req = 1'b0; i_wdt_kick = 1'b0; i_wdt_en = 1'b0;
        chk("sim_kick_sw_wins", {30'd0, o_cause}, 32'd1);
        wait_high(n);
        wait_idle(n);

        // Release timeout, repeating until the core reports release
        force0 = 1'b1;
        sw_pulse();
        wait_high(n);  chk("tmo_low_len", n, P);
        wait_low(n);   chk("tmo_release_len", n, T);
        chk("tmo_cause", {30'd0, o_cause}, 32'd3);
        wait_high(n);  chk("tmo_low_len2", n, P);
        wait_low(n);   chk("tmo_release_len2", n, T);
        @(negedge clk); force0 = 1'b0;
        wait_high(n);  chk("tmo_low_len3", n, P);
        wait_idle(n);  chk("tmo_recover_len", n, 16);
        chk("tmo_cause_hold", {30'd0, o_cause}, 32'd3);

        // Reset asserted in the fifth RELEASE cycle after a software request
        sw_pulse();
        wait_high(n);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_resetn", {31'd0, o_resetn}, 32'd0);
        chk("mid_cause", {30'd0, o_cause}, 32'd0);
        chk("mid_busy", {31'd0, o_busy}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_high(n);  chk("mid_low_len", n, P);
        wait_idle(n);
        chk("mid_idle_cause", {30'd0, o_cause}, 32'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL global_timeout: got time %0t want finish earlier", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
